// File: rtl/i2c_seq_pkg.sv
// Shared types and constants for the I2C register-access sequencer.
//   seq_state_t  : sequencer state encoding
//   seq_status_t : response status codes returned on rsp_status
//   RW_WRITE / RW_READ : value of the R/W bit appended to the 7-bit address
package i2c_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_REG,
    S_WR,
    S_RSTART,
    S_RD,
    S_DRAIN,
    S_RESP
  } seq_state_t;

  typedef enum logic [1:0] {
    ST_OK          = 2'd0,
    ST_ADDR_NACK   = 2'd1,
    ST_DATA_NACK   = 2'd2,
    ST_ARB_TIMEOUT = 2'd3
  } seq_status_t;

  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;

endpackage

// File: rtl/i2c_reg_sequencer.sv
// i2c_reg_sequencer: expands one single-byte register access into the
// i2c_master control sequence (START, address, register byte, then either a
// data write or a repeated START plus one-byte read) and returns a response.
//
// Ports:
//   clk_in, rst_n                  clock, synchronous active-low reset
//   req_valid/req_ready            request handshake (ready only in IDLE)
//   req_write, req_dev, req_reg, req_wdata   request fields, latched on accept
//   rsp_valid, rsp_rdata, rsp_status         one-cycle response strobe + data
//   m_*                            control/status to and from i2c_master
//   busy                           high whenever the sequencer is not IDLE
//
// Optional build macro:
//   I2C_SEQ_TIMEOUT_EN  enables a per-request watchdog of TIMEOUT_CYCLES
//                       cycles; on expiry the response is status 3 and the
//                       STOP drain is skipped.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | waiting for a request
// START    | START + {dev,W} + register byte requested, wait master ready
// REG      | wait for register byte result
// WR       | data byte being written, wait for completion
// RSTART   | repeated START with {dev,R}, wait for address phase result
// RD       | reading the single data byte (master NACKs it)
// DRAIN    | wait for the STOP to finish (master ready again)
// RESP     | one-cycle response strobe
module i2c_reg_sequencer
  import i2c_seq_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 4800000
) (
  input  logic       clk_in,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_write,
  input  logic [6:0] req_dev,
  input  logic [7:0] req_reg,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic [1:0] rsp_status,
  output logic [7:0] m_address,
  output logic       m_transfer_start,
  output logic       m_transfer_continues,
  output logic [7:0] m_data_tx,
  input  logic       m_transfer_ready,
  input  logic       m_interrupt,
  input  logic       m_transaction_complete,
  input  logic       m_nack,
  input  logic [7:0] m_data_rx,
  input  logic       m_address_err,
  input  logic       m_arbitration_err,
  output logic       busy
);

  // The watchdog counter is 23 bits wide; reject limits it cannot reach.
  if (TIMEOUT_CYCLES == 0 || TIMEOUT_CYCLES > 32'h007F_FFFF) begin : g_bad_timeout
    $error("i2c_reg_sequencer: TIMEOUT_CYCLES out of range for 23-bit watchdog");
  end

  seq_state_t  state;
  seq_status_t status_q;
  logic [6:0]  dev_q;
  logic [7:0]  reg_q;
  logic [7:0]  wdata_q;
  logic        write_q;
  logic        wd_expire;

  assign req_ready  = (state == S_IDLE);
  assign busy       = (state != S_IDLE);
  assign rsp_status = status_q;

`ifdef I2C_SEQ_TIMEOUT_EN
  logic [22:0] wd_cnt;

  // Cleared while IDLE, so counting starts from the acceptance edge.
  always_ff @(posedge clk_in) begin
    if (!rst_n || state == S_IDLE) wd_cnt <= '0;
    else                           wd_cnt <= wd_cnt + 23'd1;
  end

  // Fires on the edge that would make the count reach the limit.
  assign wd_expire = busy && (state != S_RESP) &&
                     ((wd_cnt + 23'd1) == 23'(TIMEOUT_CYCLES));
`else
  assign wd_expire = 1'b0;
`endif

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      state                <= S_IDLE;
      status_q             <= ST_OK;
      dev_q                <= '0;
      reg_q                <= '0;
      wdata_q              <= '0;
      write_q              <= 1'b0;
      rsp_valid            <= 1'b0;
      rsp_rdata            <= '0;
      m_address            <= '0;
      m_transfer_start     <= 1'b0;
      m_transfer_continues <= 1'b0;
      m_data_tx            <= '0;
    end else if (wd_expire) begin
      state                <= S_RESP;
      status_q             <= ST_ARB_TIMEOUT;
      rsp_rdata            <= '0;
      rsp_valid            <= 1'b1;
      m_transfer_start     <= 1'b0;
      m_transfer_continues <= 1'b0;
    end else if (m_arbitration_err && state != S_IDLE && state != S_RESP) begin
      // Lost arbitration beats any NACK reported in the same cycle.
      state                <= S_DRAIN;
      status_q             <= ST_ARB_TIMEOUT;
      rsp_rdata            <= '0;
      m_transfer_start     <= 1'b0;
      m_transfer_continues <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            dev_q                <= req_dev;
            reg_q                <= req_reg;
            wdata_q              <= req_wdata;
            write_q              <= req_write;
            status_q             <= ST_OK;
            rsp_rdata            <= '0;
            m_address            <= {req_dev, RW_WRITE};
            m_data_tx            <= req_reg;
            m_transfer_start     <= 1'b1;
            m_transfer_continues <= req_write;
            state                <= S_START;
          end
        end
        S_START: begin
          if (m_transfer_ready) begin
            m_transfer_start <= 1'b0;
            state            <= S_REG;
          end
        end
        S_REG: begin
          if (m_interrupt) begin
            if (m_address_err) begin
              status_q             <= ST_ADDR_NACK;
              m_transfer_continues <= 1'b0;
              state                <= S_DRAIN;
            end else if (m_transaction_complete && m_nack) begin
              status_q             <= ST_DATA_NACK;
              m_transfer_continues <= 1'b0;
              state                <= S_DRAIN;
            end else if (write_q) begin
              m_data_tx            <= wdata_q;
              m_transfer_continues <= 1'b0;
              state                <= S_WR;
            end else begin
              m_address            <= {dev_q, RW_READ};
              m_transfer_start     <= 1'b1;
              m_transfer_continues <= 1'b0;
              state                <= S_RSTART;
            end
          end
        end
        S_WR: begin
          if (m_interrupt && m_transaction_complete) begin
            status_q <= m_nack ? ST_DATA_NACK : ST_OK;
            state    <= S_DRAIN;
          end
        end
        S_RSTART: begin
          if (m_interrupt) begin
            m_transfer_start <= 1'b0;
            if (m_address_err) begin
              status_q <= ST_ADDR_NACK;
              state    <= S_DRAIN;
            end else begin
              state <= S_RD;
            end
          end
        end
        S_RD: begin
          // m_nack is expected here: the master NACKs the only byte read.
          if (m_interrupt && m_transaction_complete) begin
            rsp_rdata <= m_data_rx;
            status_q  <= ST_OK;
            state     <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (m_transfer_ready) begin
            rsp_valid <= 1'b1;
            state     <= S_RESP;
          end
        end
        S_RESP: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_reg_sequencer.sv
// Self-checking bench for i2c_reg_sequencer. A small i2c_master stand-in is
// driven from the single stimulus process; expected bus bytes, status and
// read data come from a per-request model built from the access rules.
module tb_i2c_reg_sequencer;

  logic       clk_in = 1'b0;
  logic       rst_n;
  logic       req_valid, req_ready, req_write;
  logic [6:0] req_dev;
  logic [7:0] req_reg, req_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic [1:0] rsp_status;
  logic [7:0] m_address, m_data_tx, m_data_rx;
  logic       m_transfer_start, m_transfer_continues;
  logic       m_transfer_ready, m_interrupt, m_transaction_complete, m_nack;
  logic       m_address_err, m_arbitration_err;
  logic       busy;

  always #5 clk_in = ~clk_in;

  i2c_reg_sequencer #(.TIMEOUT_CYCLES(1000)) dut (
    .clk_in                 (clk_in),
    .rst_n                  (rst_n),
    .req_valid              (req_valid),
    .req_ready              (req_ready),
    .req_write              (req_write),
    .req_dev                (req_dev),
    .req_reg                (req_reg),
    .req_wdata              (req_wdata),
    .rsp_valid              (rsp_valid),
    .rsp_rdata              (rsp_rdata),
    .rsp_status             (rsp_status),
    .m_address              (m_address),
    .m_transfer_start       (m_transfer_start),
    .m_transfer_continues   (m_transfer_continues),
    .m_data_tx              (m_data_tx),
    .m_transfer_ready       (m_transfer_ready),
    .m_interrupt            (m_interrupt),
    .m_transaction_complete (m_transaction_complete),
    .m_nack                 (m_nack),
    .m_data_rx              (m_data_rx),
    .m_address_err          (m_address_err),
    .m_arbitration_err      (m_arbitration_err),
    .busy                   (busy)
  );

  int n_cmp = 0;
  int n_err = 0;
  int rsp_cnt = 0;
  logic [7:0] log_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge; every response strobe is counted here.
  task automatic cycle();
    @(negedge clk_in);
    if (rsp_valid === 1'b1) rsp_cnt++;
  endtask

  task automatic idle_n(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic clr_master();
    m_interrupt = 1'b0; m_transaction_complete = 1'b0; m_nack = 1'b0;
    m_address_err = 1'b0; m_arbitration_err = 1'b0; m_transfer_ready = 1'b0;
  endtask

  // fault: 0 none, 1 address NACK, 2 register byte NACK,
  //        3 data NACK (write) / read-address NACK (read), 4 arbitration at phase ph
  task automatic run_txn(input logic wr, input logic [6:0] dev, input logic [7:0] rg,
                         input logic [7:0] wd, input logic [7:0] sd,
                         input int fault, input int ph, input bit rst_in_rd);
    logic [7:0] exp_q[$];
    int         exp_st;
    logic [7:0] exp_rd;
    bit         term0, term1;

    term0 = (fault == 1) || (fault == 2) || (fault == 4 && ph == 0);
    term1 = (fault == 3) || (fault == 4 && ph == 1);
    exp_q.push_back({dev, 1'b0});
    exp_q.push_back(rg);
    if (!term0) exp_q.push_back(wr ? wd : {dev, 1'b1});
    case (fault)
      0: exp_st = 0;
      1: exp_st = 1;
      2: exp_st = 2;
      3: exp_st = wr ? 2 : 1;
      default: exp_st = 3;
    endcase
    exp_rd = (!wr && fault == 0) ? sd : 8'h00;

    log_q.delete();
    rsp_cnt = 0;
    chk("idle_ready", req_ready, 1);
    req_valid = 1'b1; req_write = wr; req_dev = dev; req_reg = rg; req_wdata = wd;
    cycle();
    chk("accept_busy", busy, 1);
    chk("accept_ready_low", req_ready, 0);
    chk("start_asserted", m_transfer_start, 1);
    chk("start_continues", m_transfer_continues, wr);
    log_q.push_back(m_address);
    log_q.push_back(m_data_tx);
    // Keep req_valid high with garbage fields: must be ignored while busy.
    req_write = 1'($urandom); req_dev = 7'($urandom);
    req_reg = 8'($urandom); req_wdata = 8'($urandom);

    idle_n($urandom_range(2, 0));
    m_transfer_ready = 1'b1;
    cycle();
    m_transfer_ready = 1'b0;
    chk("reg_start_dropped", m_transfer_start, 0);

    idle_n($urandom_range(4, 1));
    m_interrupt = 1'b1;
    if (fault == 1) begin
      m_address_err = 1'b1; m_transaction_complete = 1'b1; m_nack = 1'b1;
    end else if (fault == 2) begin
      m_transaction_complete = 1'b1; m_nack = 1'b1;
    end else if (fault == 4 && ph == 0) begin
      m_arbitration_err = 1'b1; m_transaction_complete = 1'b1; m_nack = 1'b1;
    end
    cycle();
    clr_master();

    if (!term0) begin
      if (wr) begin
        log_q.push_back(m_data_tx);
        chk("wr_continues", m_transfer_continues, 0);
        chk("wr_start", m_transfer_start, 0);
      end else begin
        log_q.push_back(m_address);
        chk("sr_start", m_transfer_start, 1);
      end
      idle_n($urandom_range(4, 1));
      m_interrupt = 1'b1;
      if (wr) begin
        m_transaction_complete = 1'b1;
        m_nack = (fault == 3) || (fault == 4 && ph == 1);
      end else begin
        m_address_err = (fault == 3);
      end
      m_arbitration_err = (fault == 4 && ph == 1);
      cycle();
      clr_master();

      if (!wr && !term1) begin
        chk("rd_start", m_transfer_start, 0);
        chk("rd_continues", m_transfer_continues, 0);
        if (rst_in_rd) begin
          rst_n = 1'b0;
          cycle();
          rst_n = 1'b1;
          req_valid = 1'b0;
          chk("rst_ready", req_ready, 1);
          chk("rst_busy", busy, 0);
          chk("rst_start", m_transfer_start, 0);
          chk("rst_continues", m_transfer_continues, 0);
          chk("rst_address", m_address, 0);
          chk("rst_data_tx", m_data_tx, 0);
          chk("rst_rsp_valid", rsp_valid, 0);
          idle_n(6);
          chk("rst_no_rsp", rsp_cnt, 0);
          return;
        end
        idle_n($urandom_range(4, 1));
        m_interrupt = 1'b1; m_transaction_complete = 1'b1; m_data_rx = sd;
        m_arbitration_err = (fault == 4 && ph == 2);
        cycle();
        clr_master();
      end
    end

    chk("drain_busy", busy, 1);
    chk("drain_start", m_transfer_start, 0);
    chk("drain_no_rsp", rsp_cnt, 0);
    idle_n($urandom_range(3, 0));
    m_transfer_ready = 1'b1;
    cycle();
    m_transfer_ready = 1'b0;
    req_valid = 1'b0;
    chk("rsp_valid", rsp_valid, 1);
    chk("rsp_status", rsp_status, exp_st);
    chk("rsp_rdata", rsp_rdata, exp_rd);
    chk("rsp_ready_low", req_ready, 0);
    cycle();
    chk("rsp_pulse_end", rsp_valid, 0);
    chk("ready_after_rsp", req_ready, 1);
    chk("idle_after_rsp", busy, 0);
    chk("rsp_count", rsp_cnt, 1);
    chk("bus_len", log_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
      chk($sformatf("bus_byte%0d", i), log_q[i], exp_q[i]);
  endtask

  initial begin
    int k;
    rst_n = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_dev = '0; req_reg = '0; req_wdata = '0;
    m_data_rx = '0;
    clr_master();
    idle_n(3);
    chk("reset_ready", req_ready, 1);
    chk("reset_busy", busy, 0);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_start", m_transfer_start, 0);
    chk("reset_address", m_address, 0);
    chk("reset_status", rsp_status, 0);
    rst_n = 1'b1;
    idle_n(2);

    run_txn(1'b1, 7'h48, 8'h01, 8'hA5, 8'h00, 0, 0, 1'b0);
    run_txn(1'b0, 7'h48, 8'h02, 8'h00, 8'h3C, 0, 0, 1'b0);
    run_txn(1'b0, 7'h22, 8'h10, 8'h00, 8'h77, 1, 0, 1'b0);
    run_txn(1'b1, 7'h50, 8'h07, 8'h5A, 8'h00, 2, 0, 1'b0);
    run_txn(1'b1, 7'h51, 8'h08, 8'hC3, 8'h00, 3, 0, 1'b0);
    run_txn(1'b0, 7'h52, 8'h09, 8'h00, 8'hE1, 3, 0, 1'b0);
    run_txn(1'b1, 7'h10, 8'h20, 8'h11, 8'h00, 4, 0, 1'b0);
    run_txn(1'b1, 7'h11, 8'h21, 8'h22, 8'h00, 4, 1, 1'b0);
    run_txn(1'b0, 7'h12, 8'h22, 8'h00, 8'h33, 4, 2, 1'b0);

    for (int n = 0; n < 40; n++) begin
      logic wr;
      int   f;
      wr = 1'($urandom);
      f  = $urandom_range(4, 0);
      run_txn(wr, 7'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), f,
              wr ? $urandom_range(1, 0) : $urandom_range(2, 0), 1'b0);
    end

    run_txn(1'b0, 7'h3A, 8'h44, 8'h00, 8'hC3, 0, 0, 1'b1);
    run_txn(1'b0, 7'h3A, 8'h45, 8'h00, 8'h5E, 0, 0, 1'b0);

`ifdef I2C_SEQ_TIMEOUT_EN
    rsp_cnt = 0;
    req_valid = 1'b1; req_write = 1'b1; req_dev = 7'h48; req_reg = 8'h01; req_wdata = 8'hA5;
    cycle();
    req_valid = 1'b0;
    k = 0;
    while (rsp_valid !== 1'b1 && k < 3000) begin
      cycle();
      k++;
    end
    chk("timeout_cycles", k, 1000);
    chk("timeout_status", rsp_status, 3);
    chk("timeout_start", m_transfer_start, 0);
    cycle();
    chk("timeout_ready", req_ready, 1);
    chk("timeout_rsp_count", rsp_cnt, 1);
`else
    k = 0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
